// File: rtl/fft_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fft_ctrl_pkg
// Shared definitions for the iterative radix-2 DIT FFT sequencer:
//   - default geometry (AWL_DEF, BF_LAT_DEF) and the derived N / HALF_N
//   - FSM state encoding (ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE)
//   - clog2 / stage_w / half_of helpers used to size counters and ports
// -----------------------------------------------------------------------------
package fft_ctrl_pkg;

  localparam int AWL_DEF    = 5;             // RAM address width
  localparam int BF_LAT_DEF = 4;             // butterfly read-to-write latency
  localparam int N          = 2 ** AWL_DEF;  // points per transform
  localparam int HALF_N     = N / 2;         // butterflies per stage

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Smallest r with 2**r >= v (0 for v <= 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

  // Width of the stage index port: ceil(log2 AWL), never narrower than 1.
  function automatic int stage_w(input int awl);
    return (clog2(awl) < 1) ? 1 : clog2(awl);
  endfunction

  // Butterflies per stage for a given address width.
  function automatic int half_of(input int awl);
    return (1 << awl) / 2;
  endfunction

endpackage

// File: rtl/fft_iter_ctrl_if.sv
// -----------------------------------------------------------------------------
// fft_iter_ctrl_if
// Control / address bundle between the FFT sequencer and the RAM, twiddle ROM
// and butterfly datapath around it.
//   master : the sequencer (drives o_*, receives EN/START[/i_INV])
//   slave  : the host / datapath side (drives EN/START[/i_INV], receives o_*)
// Signals:
//   EN, START               global clock enable, start request
//   o_RAM_BLOCK, o_DONE     RAM ownership flag, one-cycle completion pulse
//   o_RD_EN, o_RD_A/B_ADDR  butterfly operand reads
//   o_TW_ADDR               twiddle ROM index aligned with the reads
//   o_WR_EN, o_WR_A/B_ADDR  delayed write-back
//   o_STAGE                 current stage index
// Optional (macro FFT_CTRL_INV_EN): i_INV input, o_TW_CONJ output.
// -----------------------------------------------------------------------------
interface fft_iter_ctrl_if
  import fft_ctrl_pkg::*;
#(
  parameter int AWL = AWL_DEF
) ();
  localparam int SW = stage_w(AWL);

  logic           EN;
  logic           START;
  logic           o_RAM_BLOCK;
  logic           o_DONE;
  logic           o_RD_EN;
  logic [AWL-1:0] o_RD_A_ADDR;
  logic [AWL-1:0] o_RD_B_ADDR;
  logic [AWL-2:0] o_TW_ADDR;
  logic           o_WR_EN;
  logic [AWL-1:0] o_WR_A_ADDR;
  logic [AWL-1:0] o_WR_B_ADDR;
  logic [SW-1:0]  o_STAGE;
`ifdef FFT_CTRL_INV_EN
  logic           i_INV;
  logic           o_TW_CONJ;
`endif

  modport master (
    input  EN, START,
`ifdef FFT_CTRL_INV_EN
    input  i_INV,
    output o_TW_CONJ,
`endif
    output o_RAM_BLOCK, o_DONE, o_RD_EN, o_RD_A_ADDR, o_RD_B_ADDR, o_TW_ADDR,
    output o_WR_EN, o_WR_A_ADDR, o_WR_B_ADDR, o_STAGE
  );

  modport slave (
    output EN, START,
`ifdef FFT_CTRL_INV_EN
    output i_INV,
    input  o_TW_CONJ,
`endif
    input  o_RAM_BLOCK, o_DONE, o_RD_EN, o_RD_A_ADDR, o_RD_B_ADDR, o_TW_ADDR,
    input  o_WR_EN, o_WR_A_ADDR, o_WR_B_ADDR, o_STAGE
  );

endinterface

// File: rtl/fft_addr_dly.sv
// -----------------------------------------------------------------------------
// fft_addr_dly
// DEPTH-deep shift register carrying {valid, A, B} from the butterfly read
// port to the write-back port. Advances only when en=1; rst clears it
// synchronously so pending write-backs are dropped.
// Ports:
//   clk, rst, en                 clock, sync active-high clear, enable
//   in_valid, in_a, in_b         read strobe and addresses
//   out_valid, out_a, out_b      the same values DEPTH enabled cycles later
// -----------------------------------------------------------------------------
module fft_addr_dly #(
  parameter int AW    = 5,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          in_valid,
  input  logic [AW-1:0] in_a,
  input  logic [AW-1:0] in_b,
  output logic          out_valid,
  output logic [AW-1:0] out_a,
  output logic [AW-1:0] out_b
);

  logic [DEPTH-1:0]         vld_q, vld_d;
  logic [DEPTH-1:0][AW-1:0] a_q, a_d;
  logic [DEPTH-1:0][AW-1:0] b_q, b_d;

  always_comb begin
    vld_d[0] = in_valid;
    a_d[0]   = in_a;
    b_d[0]   = in_b;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      a_d[i]   = a_q[i-1];
      b_d[i]   = b_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the whole line is reset, not just the valid bits, so a
      // discarded write-back never leaves stale addresses on the bus.
      vld_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (en) begin
      vld_q <= vld_d;
      a_q   <= a_d;
      b_q   <= b_d;
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_a     = a_q[DEPTH-1];
  assign out_b     = b_q[DEPTH-1];

endmodule

// File: rtl/fft_iter_ctrl.sv
// -----------------------------------------------------------------------------
// fft_iter_ctrl
// Sequencer for the in-place iterative radix-2 DIT FFT. On START it owns the
// data RAM, walks AWL stages of N/2 butterflies issuing read and twiddle
// addresses, drains the butterfly pipeline between stages so stage s+1 never
// reads a word stage s has not yet written, and ends with a one-cycle o_DONE.
// Input data is in bit-reversed order; the result is in natural order.
// Ports:
//   CLK, RST  clock, synchronous active-high reset
//   bus       fft_iter_ctrl_if.master (EN, START, read/twiddle/write-back
//             addresses and strobes, o_RAM_BLOCK, o_DONE, o_STAGE)
// Build option: define FFT_CTRL_INV_EN to add i_INV / o_TW_CONJ (inverse FFT
// via twiddle conjugation, latched when START is accepted).
// All outputs are registered; every flop holds while EN=0.
// -----------------------------------------------------------------------------
module fft_iter_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int AWL    = AWL_DEF,
  parameter int BF_LAT = BF_LAT_DEF
) (
  input  logic            CLK,
  input  logic            RST,
  fft_iter_ctrl_if.master bus
);

  localparam int NB = half_of(AWL);
  localparam int SW = stage_w(AWL);
  localparam int CW = (BF_LAT > 1) ? clog2(BF_LAT) : 1;

  localparam logic [AWL-2:0] K_LAST = (AWL-1)'(NB - 1);
  localparam logic [SW-1:0]  S_LAST = SW'(AWL - 1);
  localparam logic [CW-1:0]  C_LAST = CW'(BF_LAT - 1);

  // Upper-leg address: insert a 0 at bit position s of k.
  function automatic logic [AWL-1:0] leg_a(input logic [AWL-2:0] k,
                                           input logic [SW-1:0]  s);
    logic [AWL-1:0] kw, lo;
    int             sh;
    sh = int'(s);
    kw = {1'b0, k};
    lo = kw & ((AWL'(1) << sh) - AWL'(1));
    return ((kw >> sh) << (sh + 1)) | lo;
  endfunction

  // Twiddle index: position within the group scaled to the N/2-entry ROM.
  // At the last stage the mask shift wraps to zero, giving an all-ones mask.
  function automatic logic [AWL-2:0] tw_idx(input logic [AWL-2:0] k,
                                            input logic [SW-1:0]  s);
    logic [AWL-2:0] pos;
    int             sh;
    sh  = int'(s);
    pos = k & (((AWL-1)'(1) << sh) - (AWL-1)'(1));
    return pos << (AWL - 1 - sh);
  endfunction

  logic [1:0]     state_q, state_d;
  logic [AWL-2:0] k_q, k_d;
  logic [SW-1:0]  s_q, s_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           ram_block_q, ram_block_d;
  logic           done_q, done_d;
  logic           rd_en_q, rd_en_d;
  logic [AWL-1:0] rd_a_q, rd_a_d;
  logic [AWL-1:0] rd_b_q, rd_b_d;
  logic [AWL-2:0] tw_q, tw_d;
  logic [SW-1:0]  stage_q, stage_d;

  // Sequencing: k walks the butterflies of a stage, cnt times the drain.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d = state_q;
    k_d     = k_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          state_d = ST_RUN;
          k_d     = '0;
          s_d     = '0;
        end
      end
      ST_RUN: begin
        if (k_q == K_LAST) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == C_LAST) begin
          if (s_q == S_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            s_d     = s_q + 1'b1;
            k_d     = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        k_d     = '0;
        s_d     = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered copy is
  // aligned with the state it describes.
  always_comb begin
    rd_en_d     = (state_d == ST_RUN);
    ram_block_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d      = (state_d == ST_DONE);
    stage_d     = s_d;
    rd_a_d      = '0;
    rd_b_d      = '0;
    tw_d        = '0;
    if (rd_en_d) begin
      rd_a_d = leg_a(k_d, s_d);
      rd_b_d = leg_a(k_d, s_d) + (AWL'(1) << int'(s_d));
      tw_d   = tw_idx(k_d, s_d);
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    if (RST) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      s_q         <= '0;
      cnt_q       <= '0;
      ram_block_q <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_a_q      <= '0;
      rd_b_q      <= '0;
      tw_q        <= '0;
      stage_q     <= '0;
    end else if (bus.EN) begin
      state_q     <= state_d;
      k_q         <= k_d;
      s_q         <= s_d;
      cnt_q       <= cnt_d;
      ram_block_q <= ram_block_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_a_q      <= rd_a_d;
      rd_b_q      <= rd_b_d;
      tw_q        <= tw_d;
      stage_q     <= stage_d;
    end
  end

  logic           wr_en;
  logic [AWL-1:0] wr_a, wr_b;

  // Write-back replays the registered read strobe/addresses BF_LAT enabled
  // cycles later, matching the butterfly pipeline.
  fft_addr_dly #(
    .AW    (AWL),
    .DEPTH (BF_LAT)
  ) u_dly (
    .clk       (CLK),
    .rst       (RST),
    .en        (bus.EN),
    .in_valid  (rd_en_q),
    .in_a      (rd_a_q),
    .in_b      (rd_b_q),
    .out_valid (wr_en),
    .out_a     (wr_a),
    .out_b     (wr_b)
  );

`ifdef FFT_CTRL_INV_EN
  logic conj_q, conj_d;

  // Captured on the IDLE->RUN transition, held while the RAM is owned.
  always_comb begin
    conj_d = 1'b0;
    if (ram_block_d) conj_d = (state_q == ST_IDLE) ? bus.i_INV : conj_q;
  end

  always_ff @(posedge CLK) begin
    if (RST)         conj_q <= 1'b0;
    else if (bus.EN) conj_q <= conj_d;
  end

  assign bus.o_TW_CONJ = conj_q;
`endif

  assign bus.o_RAM_BLOCK = ram_block_q;
  assign bus.o_DONE      = done_q;
  assign bus.o_RD_EN     = rd_en_q;
  assign bus.o_RD_A_ADDR = rd_a_q;
  assign bus.o_RD_B_ADDR = rd_b_q;
  assign bus.o_TW_ADDR   = tw_q;
  assign bus.o_STAGE     = stage_q;
  assign bus.o_WR_EN     = wr_en;
  assign bus.o_WR_A_ADDR = wr_a;
  assign bus.o_WR_B_ADDR = wr_b;

endmodule

// File: doc/fft_iter_ctrl.md
Name: fft_iter_ctrl

Overview:
Sequencer for the in-place iterative radix-2 DIT FFT core. On START it takes ownership of the data RAM and blocks external port access. It then walks all AWL stages of N/2 butterflies, issuing butterfly read addresses, the twiddle ROM address and delayed write-back addresses matched to the butterfly pipeline latency. It signals completion with a one-cycle DONE pulse. RAM contents are in bit-reversed order before START; the result is in natural order.

Parameters:
AWL, 5, RAM address width; N = 2**AWL points (32)
BF_LAT, 4, butterfly pipeline latency in cycles from read to write-back (>=1)

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  synchronous, active-high reset
EN  in  1  global clock enable; when 0, all state, counters and the delay line hold
START  in  1  start request, sampled only in IDLE with EN=1
o_RAM_BLOCK  out  1  1 while the FFT owns the RAM (RUN/DRAIN); external i_*_ADDR/i_RAM_Wr must be ignored
o_DONE  out  1  one-cycle completion pulse
o_RD_EN  out  1  butterfly operand read strobe
o_RD_A_ADDR  out  AWL  upper-leg read address
o_RD_B_ADDR  out  AWL  lower-leg read address
o_TW_ADDR  out  AWL-1  twiddle ROM index, aligned with o_RD_EN
o_WR_EN  out  1  write-back strobe
o_WR_A_ADDR  out  AWL  write-back address, upper leg
o_WR_B_ADDR  out  AWL  write-back address, lower leg
o_STAGE  out  ceil(log2 AWL)  current stage index s

Behaviour:
- All outputs are registered. On reset every output is 0, state=IDLE, counters=0 and the delay line is cleared.
- FSM states:
  - IDLE -> RUN on START&EN.
  - RUN: k counts 0..N/2-1 with o_RD_EN=1; after k=N/2-1 go to DRAIN.
  - DRAIN: BF_LAT cycles with o_RD_EN=0. At the end, if s<AWL-1 then s++, k=0 and go to RUN; otherwise go to DONE.
  - DONE: one cycle, o_DONE=1, then IDLE.
- Address rules for stage s and butterfly k:
  - half = 1<<s; grp = k>>s; pos = k & (half-1).
  - A = (grp<<(s+1)) | pos; B = A + half.
  - TW = pos << (AWL-1-s).
- Write-back: o_WR_EN/o_WR_A_ADDR/o_WR_B_ADDR equal the o_RD_EN/A/B values from exactly BF_LAT enabled cycles earlier.
- The DRAIN state guarantees that the last write of stage s lands before the first read of stage s+1 (no RAW hazard).
- Timing, with START sampled at edge E0 and counting enabled cycles after E0:
  - o_RAM_BLOCK and o_RD_EN rise at cycle 1.
  - Stage s reads occupy cycles 1+s*(N/2+BF_LAT) .. N/2+s*(N/2+BF_LAT).
  - o_DONE occurs at cycle AWL*(N/2+BF_LAT)+1. With defaults that is 101, the last write is at cycle 100, and o_RAM_BLOCK drops at cycle 101.
- START while not IDLE: ignored. START held high: a new run starts only after returning to IDLE.
- RST and START asserted together: reset wins.
- RST mid-run: immediate return to IDLE, outputs 0, pending write-backs discarded.
- EN=0 mid-run: full freeze, including the delay line. Resuming continues seamlessly, and the cycle counts above are counted in enabled cycles only.

Optional Feature:
FFT_CTRL_INV_EN:
- Defined: adds input i_INV (1 bit), latched on START acceptance, and output o_TW_CONJ equal to the latched value, held for the whole run and cleared in IDLE or on reset. The butterfly conjugates twiddles for an inverse FFT.
- Undefined: neither port exists; forward FFT only.

Decomposition:
- Package fft_ctrl_pkg holds:
  - state encoding (IDLE, RUN, DRAIN, DONE)
  - localparam derivations N=2**AWL, HALF_N=N/2
  - stage-width function clog2
- One sub-module, fft_addr_dly: a BF_LAT-deep enable-gated shift register carrying {valid, A, B}, with synchronous clear on RST. It produces the o_WR_* outputs.

Test Plan:
1. Reset: RST=1 for 2 cycles with START=1 -> all outputs 0, no run. Release, then START pulse -> o_RAM_BLOCK=1 at cycle 1; o_DONE only at cycle 101; 80 o_RD_EN and 80 o_WR_EN cycles total.
2. Address check, stage 0: k=0 gives A=0,B=1,TW=0; k=1 gives A=2,B=3,TW=0. Stage 1, k=3: A=5,B=7,TW=8. Stage 4, k=3: A=3,B=19,TW=3.
3. Write-back alignment: every o_WR_A/B_ADDR equals the read address BF_LAT=4 cycles earlier. No stage s+1 read occurs before the final stage s write (first stage-1 read at cycle 21, last stage-0 write at cycle 20).
4. EN=0 for 7 cycles during stage 2 -> outputs frozen and o_DONE delayed to cycle 108; the address sequence is identical to run 1.
5. RST at cycle 50 -> next cycle IDLE, o_RAM_BLOCK=0, no further o_WR_EN. A new START gives a clean full run with o_DONE 101 cycles later. A START pulse at cycle 30 of a run is ignored.
6. With FFT_CTRL_INV_EN: i_INV=1 at START -> o_TW_CONJ=1 cycles 1..100 and 0 after o_DONE. A run with i_INV=0 -> o_TW_CONJ=0 throughout.
